// File: rtl/bus_pkg.sv
// Shared types and default widths for the serial bus master port and its helpers.
package bus_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_TIMEOUT    = 255;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_ADDR  = 3'd2,
      S_WDATA = 3'd3,
      S_WAIT  = 3'd4,
      S_RDATA = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Device request port plus the 1-bit arbitrated bus of bus_master_port.
// dvalid/dready: a request is taken on a rising edge with both high; dready then
// stays low until the transaction ends (DONE or timeout) and dvalid is ignored.
interface bus_master_port_if #(
   parameter int ADDR_WIDTH = bus_pkg::DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = bus_pkg::DEF_DATA_WIDTH
);
   logic                  dvalid;
   logic                  dmode;
   logic [ADDR_WIDTH-1:0] daddr;
   logic [DATA_WIDTH-1:0] dwdata;
   logic                  dready;
   logic [DATA_WIDTH-1:0] drdata;
   logic                  derr;
   logic                  mbreq;
   logic                  mbgrant;
   logic                  mwdata;
   logic                  mvalid;
   logic                  mmode;
   logic                  mrdata;
   logic                  mrvalid;
   logic                  sready;

   modport master (
      input  dvalid, dmode, daddr, dwdata, mbgrant, mrdata, mrvalid, sready,
      output dready, drdata, derr, mbreq, mwdata, mvalid, mmode
   );

   modport slave (
      output dvalid, dmode, daddr, dwdata, mbgrant, mrdata, mrvalid, sready,
      input  dready, drdata, derr, mbreq, mwdata, mvalid, mmode
   );
endinterface

// File: rtl/bus_shift_reg.sv
// Parallel-load / serial-shift register, LSB first: a shift moves every bit one
// place toward bit 0 and enters shift_in at the MSB.
module bus_shift_reg #(
   parameter int WIDTH = bus_pkg::DEF_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             shift_in,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = {shift_in, q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/bus_master_port.sv
// Serial bus master port: takes one device request at a time and moves it over a
// 1-bit arbitrated bus, restarting on grant loss and aborting on slave timeout.
module bus_master_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rstn,
   bus_master_port_if.master bus,
   output state_t            dbg_state
);
   localparam int SW = max_int(ADDR_WIDTH, DATA_WIDTH);
   localparam int CW = (SW > 1) ? $clog2(SW) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [TW-1:0]         wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mode_q, mode_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
   logic                  derr_q, derr_d;

   logic                  tx_load, tx_shift, rx_shift, stall, shifting;
   logic [SW-1:0]         tx_load_val, tx_q;
   logic [DATA_WIDTH-1:0] rx_q;
   logic                  unused_bits;

   bus_shift_reg #(.WIDTH(SW)) u_tx (
      .clk(clk), .rstn(rstn), .load(tx_load), .load_val(tx_load_val),
      .shift(tx_shift), .shift_in(1'b0), .q(tx_q)
   );

   bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx (
      .clk(clk), .rstn(rstn), .load(1'b0), .load_val('0),
      .shift(rx_shift), .shift_in(bus.mrdata), .q(rx_q)
   );

   // Upper tx bits and rx bit 0 are only consumed inside the shift registers.
   assign unused_bits = ^{tx_q[SW-1:1], rx_q[0]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mode_d      = mode_q;
      drdata_d    = drdata_q;
      derr_d      = 1'b0;
      tx_load     = 1'b0;
      tx_load_val = '0;
      tx_load_val[ADDR_WIDTH-1:0] = addr_q;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      stall       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.dvalid) begin
               addr_d  = bus.daddr;
               wdata_d = bus.dwdata;
               mode_d  = bus.dmode;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Address is reloaded every cycle here so a lost grant restarts at bit 0.
            tx_load = 1'b1;
            if (bus.mbgrant) begin
               state_d = S_ADDR;
               cnt_d   = '0;
            end
         end
         S_ADDR: begin
            if (!bus.mbgrant) begin
               state_d = S_REQ;
               cnt_d   = '0;
            end else if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
               cnt_d  = '0;
               wcnt_d = '0;
               if (mode_q) begin
                  state_d     = S_WDATA;
                  tx_load     = 1'b1;
                  tx_load_val = '0;
                  tx_load_val[DATA_WIDTH-1:0] = wdata_q;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               tx_shift = 1'b1;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         S_WDATA: begin
            if (!bus.mbgrant) begin
               state_d = S_REQ;
               cnt_d   = '0;
            end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               wcnt_d  = '0;
            end else begin
               tx_shift = 1'b1;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            if (mode_q) begin
               if (bus.sready) state_d = S_DONE;
               else            stall   = 1'b1;
            end else if (bus.mrvalid) begin
               rx_shift = 1'b1;
               cnt_d    = CW'(1);
               wcnt_d   = '0;
               state_d  = S_RDATA;
            end else begin
               stall = 1'b1;
            end
         end
         S_RDATA: begin
            if (bus.mrvalid) begin
               rx_shift = 1'b1;
               wcnt_d   = '0;
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  drdata_d = {bus.mrdata, rx_q[DATA_WIDTH-1:1]};
                  cnt_d    = '0;
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               stall = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (stall) begin
         if (wcnt_q == TW'(TIMEOUT - 1)) begin
            derr_d  = 1'b1;
            state_d = S_IDLE;
            wcnt_d  = '0;
            cnt_d   = '0;
         end else begin
            wcnt_d = wcnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wcnt_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mode_q   <= 1'b0;
         drdata_q <= '0;
         derr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mode_q   <= mode_d;
         drdata_q <= drdata_d;
         derr_q   <= derr_d;
      end
   end

   assign shifting    = (state_q == S_ADDR) || (state_q == S_WDATA);
   assign bus.dready  = (state_q == S_IDLE);
   assign bus.mbreq   = (state_q == S_REQ) || shifting ||
                        (state_q == S_WAIT) || (state_q == S_RDATA);
   assign bus.mvalid  = shifting;
   assign bus.mwdata  = shifting ? tx_q[0] : 1'b0;
   assign bus.mmode   = bus.mbreq ? mode_q : 1'b0;
   assign bus.drdata  = drdata_q;
   assign bus.derr    = derr_q;
   assign dbg_state   = state_q;
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table of transactions plus hand sequences for
// grant loss, dvalid noise, timeout and mid-transfer reset.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 20;

  typedef struct {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            grant_dly;
    int            resp_dly;
    logic [DW-1:0] exp_drdata;
  } vec_t;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  state_t dbg_state;

  bus_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [0:0]    bit_q[$];
  logic [DW-1:0] exp_q[$];
  logic          cur_mode;
  logic          noise_en;
  int            checks;
  int            errors;
  vec_t          vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge, input drive 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rstn) begin
      if (bus.mvalid && bus.mbgrant) begin
        if (bit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL serial_bit actual=extra_bit required=none");
        end else begin
          check("serial_bit", 32'(bus.mwdata), 32'(bit_q.pop_front()));
        end
        check("mmode", 32'(bus.mmode), 32'(cur_mode));
      end
      if (dbg_state == S_DONE || bus.derr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drdata actual=extra_completion required=none");
        end else begin
          check("drdata", 32'(bus.drdata), 32'(exp_q.pop_front()));
        end
      end
    end
    @(posedge clk);
    #1;
    if (noise_en) begin
      if (dbg_state != S_IDLE && dbg_state != S_DONE) begin
        bus.dvalid = 1'($urandom_range(0, 1));
        bus.dmode  = 1'($urandom_range(0, 1));
        bus.daddr  = AW'($urandom);
        bus.dwdata = DW'($urandom);
      end else begin
        bus.dvalid = 1'b0;
      end
    end
  endtask

  task automatic push_stream(input vec_t v);
    for (int i = 0; i < AW; i++) bit_q.push_back(v.addr[i]);
    if (v.mode) for (int i = 0; i < DW; i++) bit_q.push_back(v.wdata[i]);
  endtask

  task automatic wait_state(input state_t s, input string name);
    int guard = 0;
    while (dbg_state != s && guard < 200) begin
      tick();
      guard++;
    end
    check(name, 32'(dbg_state), 32'(s));
  endtask

  task automatic issue(input vec_t v);
    int guard = 0;
    while (!bus.dready && guard < 50) begin
      tick();
      guard++;
    end
    check("dready_idle", 32'(bus.dready), 32'd1);
    bus.dvalid = 1'b1;
    bus.dmode  = v.mode;
    bus.daddr  = v.addr;
    bus.dwdata = v.wdata;
    cur_mode   = v.mode;
    push_stream(v);
    exp_q.push_back(v.exp_drdata);
    tick();
    bus.dvalid = 1'b0;
    check("dready_busy", 32'(bus.dready), 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input int drop_at, input bit noisy);
    issue(v);
    noise_en = noisy;
    repeat (v.grant_dly) tick();
    bus.mbgrant = 1'b1;
    if (drop_at >= 0) begin
      tick();
      repeat (drop_at) tick();
      bus.mbgrant = 1'b0;
      bit_q.delete();
      push_stream(v);
      tick();
      check("mvalid_after_drop", 32'(bus.mvalid), 32'd0);
      check("mbreq_after_drop", 32'(bus.mbreq), 32'd1);
      repeat (2) tick();
      bus.mbgrant = 1'b1;
    end
    wait_state(S_WAIT, "reach_wait");
    // Grant loss after the shift phase must not disturb the transaction.
    bus.mbgrant = 1'b0;
    repeat (v.resp_dly) tick();
    if (v.mode) begin
      bus.sready = 1'b1;
      tick();
      bus.sready = 1'b0;
    end else begin
      for (int i = 0; i < DW; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) begin
          bus.mrvalid = 1'b0;
          tick();
        end
        bus.mrvalid = 1'b1;
        bus.mrdata  = v.rdata[i];
        tick();
      end
      bus.mrvalid = 1'b0;
    end
    noise_en   = 1'b0;
    bus.dvalid = 1'b0;
    check("done_state", 32'(dbg_state), 32'(S_DONE));
    check("mbreq_done", 32'(bus.mbreq), 32'd0);
    check("mvalid_done", 32'(bus.mvalid), 32'd0);
    tick();
    check("dready_after_done", 32'(bus.dready), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   k;
    checks = 0;
    errors = 0;
    noise_en = 1'b0;
    cur_mode = 1'b0;
    bus.dvalid = 1'b0;
    bus.dmode = 1'b0;
    bus.daddr = '0;
    bus.dwdata = '0;
    bus.mbgrant = 1'b0;
    bus.mrdata = 1'b0;
    bus.mrvalid = 1'b0;
    bus.sready = 1'b0;

    //            mode  addr      wdata  rdata  gnt rsp exp_drdata
    vecs[0] = '{1'b1, 16'h4001, 8'hA5, 8'h00, 3, 2, 8'h00};
    vecs[1] = '{1'b0, 16'h4001, 8'h00, 8'h3C, 1, 0, 8'h3C};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h00, 8'h00, 0, 0, 8'h3C};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'hFF, 2, 3, 8'hFF};
    vecs[4] = '{1'b0, 16'h8001, 8'h00, 8'h81, 0, 1, 8'h81};
    vecs[5] = '{1'b1, 16'h1234, 8'h5A, 8'h00, 4, 5, 8'h81};

    repeat (3) tick();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_dready", 32'(bus.dready), 32'd1);
    check("rst_drdata", 32'(bus.drdata), 32'd0);
    check("rst_derr", 32'(bus.derr), 32'd0);
    check("rst_mbreq", 32'(bus.mbreq), 32'd0);
    check("rst_mvalid", 32'(bus.mvalid), 32'd0);
    check("rst_mwdata", 32'(bus.mwdata), 32'd0);
    check("rst_mmode", 32'(bus.mmode), 32'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i], -1, 1'b0);

    // Grant lost while address bit 5 is on the wire.
    v = '{1'b1, 16'hBEEF, 8'hC3, 8'h00, 1, 1, 8'h81};
    run_txn(v, 5, 1'b0);

    // dvalid and request fields toggling for the whole transaction.
    v = '{1'b0, 16'h2468, 8'h00, 8'h96, 2, 2, 8'h96};
    run_txn(v, -1, 1'b1);
    v = '{1'b1, 16'h1357, 8'h69, 8'h00, 1, 3, 8'h96};
    run_txn(v, -1, 1'b1);

    // Read with no slave response: timeout abort, drdata untouched.
    v = '{1'b0, 16'h0F0F, 8'h00, 8'h00, 1, 0, 8'h96};
    issue(v);
    tick();
    bus.mbgrant = 1'b1;
    wait_state(S_WAIT, "reach_wait_to");
    bus.mbgrant = 1'b0;
    k = 0;
    while (!bus.derr && k < TO + 10) begin
      tick();
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TO));
    check("dready_at_derr", 32'(bus.dready), 32'd1);
    tick();
    check("derr_one_cycle", 32'(bus.derr), 32'd0);

    // Reset while write-data bit 3 is being shifted.
    v = '{1'b1, 16'hA5A5, 8'hF0, 8'h00, 0, 0, 8'h96};
    issue(v);
    bus.mbgrant = 1'b1;
    wait_state(S_WDATA, "reach_wdata");
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    check("rst_mid_mbreq", 32'(bus.mbreq), 32'd0);
    check("rst_mid_mvalid", 32'(bus.mvalid), 32'd0);
    check("rst_mid_dready", 32'(bus.dready), 32'd1);
    check("rst_mid_drdata", 32'(bus.drdata), 32'd0);
    bit_q.delete();
    void'(exp_q.pop_back());
    bus.mbgrant = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    v = '{1'b1, 16'h4001, 8'hA5, 8'h00, 3, 2, 8'h00};
    run_txn(v, -1, 1'b0);

    check("bit_q_empty", 32'(bit_q.size()), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
